mtip_tx_ipg: RTL and testbench
==============================

// Module: mtip_tx_ipg
// PURPOSE
//  TX-side frame buffer and pacer that feeds the MTIP core transmit FIFO interface.
//  Stores frames from the upstream frame builder and forwards only complete frames
//  (store-and-forward), with a cut-through fallback when the buffer is full.
//  Inserts a programmable minimum inter-packet gap of idle write cycles after every EOP.
//  Sits between the FC frame generator and the MTIP TX FIFO write port.
// PARAMETERS
//  DEPTH    1024  buffer depth in 32-bit words; power of 2, >= 8; must exceed max FC frame (537 words)
//  IPG_CNT  2     minimum idle cycles (oMTIP_WREN=0) between EOP word and next SOP word; 1..15
// PORTS
//  iCLK         in   1   212.5 MHz clock
//  iRESET       in   1   asynchronous, active-high reset
//  iDATA        in   32  upstream frame data
//  iDVAL        in   1   upstream word valid; accepted when oRDY=1
//  iSOP         in   1   first word of frame (qualified by iDVAL)
//  iEOP         in   1   last word of frame (qualified by iDVAL)
//  iERR         in   1   frame error, sampled only with iEOP
//  oRDY         out  1   buffer can accept a word (= !oFIFO_FULL)
//  oMTIP_DATA   out  32  data to MTIP TX FIFO
//  oMTIP_WREN   out  1   MTIP TX FIFO write enable
//  oMTIP_SOP    out  1   start of packet, valid with oMTIP_WREN
//  oMTIP_EOP    out  1   end of packet, valid with oMTIP_WREN
//  oMTIP_ERR    out  1   errored frame, valid with oMTIP_WREN and oMTIP_EOP
//  iMTIP_RDY    in   1   MTIP TX FIFO has space; no word is popped while low
//  oFRM_CNT     out  clog2(DEPTH+1)  complete frames (EOP written, not yet read) in buffer
//  oDROP_CNT    out  16  saturating count of discarded/corrected input words
//  oFIFO_FULL   out  1   buffer full
//  oFIFO_EMPTY  out  1   buffer empty
// BEHAVIOUR
//  Reset: all outputs 0 except oRDY=1, oFIFO_EMPTY=1; FSM=IDLE; pointers, counts, IPG counter cleared.
//  Write side: word = {ERR&EOP, EOP, SOP, DATA}, width 35; tracks inFrame flag.
//   - iDVAL & !inFrame & !iSOP: discarded, oDROP_CNT++.
//   - iDVAL & inFrame & iSOP: written with SOP bit forced 0, oDROP_CNT++.
//   - iDVAL & !oRDY: word lost, oDROP_CNT++ (upstream protocol violation).
//   - SOP sets inFrame; EOP clears it; SOP&EOP is a one-word frame.
//  oFRM_CNT: +1 on EOP word written, -1 on EOP word popped; both in the same cycle -> unchanged.
//  Pop: FIFO word is popped in cycle N; oMTIP_* are registered and present it in N+1 with oMTIP_WREN=1.
//  oMTIP_DATA/SOP/EOP/ERR are 0 whenever oMTIP_WREN=0.
//  FSM:
//   IDLE: pop if iMTIP_RDY & !empty & (oFRM_CNT>0 | full) -> XMIT (head word is always SOP).
//   XMIT: pop every cycle with iMTIP_RDY & !empty; popped word with EOP -> IPG, load counter=IPG_CNT.
//         Empty mid-frame (cut-through case) or iMTIP_RDY low: stall, no pop.
//   IPG:  no pops; counter decrements each cycle; at 1 -> IDLE.
//  With back-to-back buffered frames and iMTIP_RDY=1: exactly IPG_CNT cycles with oMTIP_WREN=0
//   between EOP and next SOP. Gap cycles elapse regardless of iMTIP_RDY.
//  Full & oFRM_CNT=0 (oversize frame): cut-through start prevents deadlock.
//  Reset mid-frame: buffer flushed, partial frame discarded, no output pulse on reset release.
// TESTING
//  1) Frame of 4 words (SOP..EOP), iMTIP_RDY=1 -> 4 consecutive WREN, SOP on 1st, EOP on 4th, data intact.
//  2) Three 3-word frames written back-to-back, IPG_CNT=2 -> exactly 2 idle cycles between each EOP and next SOP.
//  3) 6-word frame, iMTIP_RDY low 3 cycles after 2nd output word -> WREN gap of 3, data order preserved, oFRM_CNT 1->0.
//  4) Words without SOP, then mid-frame SOP -> oDROP_CNT=2, output frame SOP only on true first word.
//  5) Fill DEPTH words with no EOP -> oRDY=0, cut-through starts, EOP later emitted, no deadlock.
//  6) iRESET asserted mid-output -> WREN=0 immediately, oFIFO_EMPTY=1, oFRM_CNT=0, next frame sent cleanly.

Source files
------------

// File: rtl/mtip_tx_ipg.sv
// mtip_tx_ipg: store-and-forward TX frame buffer feeding the MTIP TX FIFO,
// with cut-through fallback when full and a programmable inter-packet gap.
module mtip_tx_ipg #(
  parameter int DEPTH   = 1024,
  parameter int IPG_CNT = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic [31:0]   iDATA,
  input  logic          iDVAL,
  input  logic          iSOP,
  input  logic          iEOP,
  input  logic          iERR,
  output logic          oRDY,
  output logic [31:0]   oMTIP_DATA,
  output logic          oMTIP_WREN,
  output logic          oMTIP_SOP,
  output logic          oMTIP_EOP,
  output logic          oMTIP_ERR,
  input  logic          iMTIP_RDY,
  output logic [CW-1:0] oFRM_CNT,
  output logic [15:0]   oDROP_CNT,
  output logic          oFIFO_FULL,
  output logic          oFIFO_EMPTY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XMIT,
    S_IPG
  } state_t;

  // word layout: {err, eop, sop, data}
  logic [34:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_frm_cnt;
  logic [15:0]   r_drop;
  logic          r_in_frame;
  state_t        r_state;
  logic [3:0]    r_ipg;

  logic [31:0]   r_o_data;
  logic          r_o_wren;
  logic          r_o_sop;
  logic          r_o_eop;
  logic          r_o_err;

  logic          w_full;
  logic          w_empty;
  logic          w_acc;
  logic          w_wr;
  logic          w_drop;
  logic          w_pop;
  logic          w_frm_inc;
  logic          w_frm_dec;
  logic [34:0]   w_wword;
  logic [34:0]   w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_acc   = iDVAL & ~w_full;
  assign w_wr    = w_acc & (r_in_frame | iSOP);

  assign w_drop = iDVAL & (w_full
                | (~r_in_frame & ~iSOP)
                | (r_in_frame & iSOP));

  assign w_wword = {iERR & iEOP, iEOP,
                    iSOP & ~r_in_frame, iDATA};
  assign w_head  = r_mem[r_rd_ptr];

  assign w_frm_inc = w_wr & iEOP;
  assign w_frm_dec = w_pop & w_head[33];

  // Full with no complete frame means an oversize frame: start cut-through.
  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      S_IDLE:
        w_pop = iMTIP_RDY & ~w_empty
              & ((r_frm_cnt != '0) | w_full);
      S_XMIT:
        w_pop = iMTIP_RDY & ~w_empty;
      default:
        w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= w_wword;
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_frm_cnt  <= '0;
      r_drop     <= '0;
      r_in_frame <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_in_frame <= ~iEOP;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_frm_inc, w_frm_dec})
        2'b10:   r_frm_cnt <= r_frm_cnt + CW'(1);
        2'b01:   r_frm_cnt <= r_frm_cnt - CW'(1);
        default: r_frm_cnt <= r_frm_cnt;
      endcase
      if (w_drop && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state  <= S_IDLE;
      r_ipg    <= '0;
      r_o_data <= '0;
      r_o_wren <= 1'b0;
      r_o_sop  <= 1'b0;
      r_o_eop  <= 1'b0;
      r_o_err  <= 1'b0;
    end else begin
      r_o_wren <= w_pop;
      r_o_data <= w_pop ? w_head[31:0] : '0;
      r_o_sop  <= w_pop & w_head[32];
      r_o_eop  <= w_pop & w_head[33];
      r_o_err  <= w_pop & w_head[34];
      unique case (r_state)
        S_IDLE, S_XMIT: begin
          if (w_pop) begin
            if (w_head[33]) begin
              r_state <= S_IPG;
              r_ipg   <= 4'(IPG_CNT);
            end else begin
              r_state <= S_XMIT;
            end
          end
        end
        S_IPG: begin
          if (r_ipg <= 4'd1) begin
            r_state <= S_IDLE;
            r_ipg   <= '0;
          end else begin
            r_ipg <= r_ipg - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ipg   <= '0;
        end
      endcase
    end
  end

  assign oRDY        = ~w_full;
  assign oFIFO_FULL  = w_full;
  assign oFIFO_EMPTY = w_empty;
  assign oFRM_CNT    = r_frm_cnt;
  assign oDROP_CNT   = r_drop;
  assign oMTIP_DATA  = r_o_data;
  assign oMTIP_WREN  = r_o_wren;
  assign oMTIP_SOP   = r_o_sop;
  assign oMTIP_EOP   = r_o_eop;
  assign oMTIP_ERR   = r_o_err;

endmodule

// File: tb/tb_mtip_tx_ipg.sv
// tb_mtip_tx_ipg: random frames checked against a word-stream
// scoreboard plus gap/counter expectations derived from frame rules.
module tb_mtip_tx_ipg;

  localparam int DEPTH = 16;
  localparam int IPG   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          iCLK = 1'b0;
  logic          iRESET;
  logic [31:0]   iDATA;
  logic          iDVAL;
  logic          iSOP;
  logic          iEOP;
  logic          iERR;
  logic          oRDY;
  logic [31:0]   oMTIP_DATA;
  logic          oMTIP_WREN;
  logic          oMTIP_SOP;
  logic          oMTIP_EOP;
  logic          oMTIP_ERR;
  logic          iMTIP_RDY;
  logic [CW-1:0] oFRM_CNT;
  logic [15:0]   oDROP_CNT;
  logic          oFIFO_FULL;
  logic          oFIFO_EMPTY;

  mtip_tx_ipg #(.DEPTH(DEPTH), .IPG_CNT(IPG)) dut (
    .iCLK        (iCLK),
    .iRESET      (iRESET),
    .iDATA       (iDATA),
    .iDVAL       (iDVAL),
    .iSOP        (iSOP),
    .iEOP        (iEOP),
    .iERR        (iERR),
    .oRDY        (oRDY),
    .oMTIP_DATA  (oMTIP_DATA),
    .oMTIP_WREN  (oMTIP_WREN),
    .oMTIP_SOP   (oMTIP_SOP),
    .oMTIP_EOP   (oMTIP_EOP),
    .oMTIP_ERR   (oMTIP_ERR),
    .iMTIP_RDY   (iMTIP_RDY),
    .oFRM_CNT    (oFRM_CNT),
    .oDROP_CNT   (oDROP_CNT),
    .oFIFO_FULL  (oFIFO_FULL),
    .oFIFO_EMPTY (oFIFO_EMPTY)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [34:0] exp_q[$];
  logic        m_in   = 1'b0;
  int          m_drop = 0;
  logic        rnd_rdy = 1'b0;

  // monitor state
  int   n_seen   = 0;
  int   idle_run = 0;
  logic have_eop = 1'b0;
  int   gap_q[$];
  int   sop_gap_q[$];

  always @(negedge iCLK) begin
    logic [34:0] got;
    logic [34:0] want;
    got = {oMTIP_ERR, oMTIP_EOP, oMTIP_SOP, oMTIP_DATA};
    if (iRESET) begin
      idle_run = 0;
      have_eop = 1'b0;
    end else if (oMTIP_WREN) begin
      chk("sb_avail", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        chk("word", 64'(got), 64'(want));
      end
      gap_q.push_back(idle_run);
      if (got[32]) begin
        sop_gap_q.push_back(idle_run);
        if (have_eop)
          chk("ipg_min", 64'(idle_run >= IPG), 1);
      end
      if (got[33])
        have_eop = 1'b1;
      idle_run = 0;
      n_seen++;
    end else begin
      chk("idle_zero", 64'(got), 0);
      idle_run++;
    end
  end

  task automatic rnd();
    if (rnd_rdy)
      iMTIP_RDY = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_accept(input logic [31:0] d,
                              input logic s, e, r);
    if (!m_in && !s) begin
      m_drop++;
    end else begin
      if (m_in && s)
        m_drop++;
      exp_q.push_back({r & e, e, s & !m_in, d});
      m_in = !e;
    end
  endtask

  task automatic put_word(input logic [31:0] d,
                          input logic s, e, r);
    int t = 0;
    iDVAL = 1'b0;
    while (!oRDY && t < 2000) begin
      rnd();
      @(negedge iCLK);
      t++;
    end
    if (t >= 2000)
      chk("rdy_wait", 64'(oRDY), 1);
    iDVAL = 1'b1;
    iDATA = d;
    iSOP  = s;
    iEOP  = e;
    iERR  = r;
    if (oRDY)
      model_accept(d, s, e, r);
    rnd();
    @(negedge iCLK);
    iDVAL = 1'b0;
    iSOP  = 1'b0;
    iEOP  = 1'b0;
    iERR  = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic err);
    for (int i = 0; i < len; i++)
      put_word($urandom, i == 0, i == len - 1, err);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rnd();
      @(negedge iCLK);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      rnd();
      @(negedge iCLK);
      t++;
    end
    if (exp_q.size() != 0)
      chk("drain", 64'(exp_q.size()), 0);
    idle(IPG + 4);
  endtask

  task automatic wait_seen(input int n);
    int t = 0;
    while (n_seen < n && t < 1000) begin
      @(negedge iCLK);
      #1;
      t++;
    end
    if (n_seen < n)
      chk("wait_seen", 64'(n_seen), 64'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int s;
    int mx;
    logic [15:0] d0;
    iRESET    = 1'b1;
    iDATA     = '0;
    iDVAL     = 1'b0;
    iSOP      = 1'b0;
    iEOP      = 1'b0;
    iERR      = 1'b0;
    iMTIP_RDY = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("rst_rdy",   64'(oRDY), 1);
    chk("rst_empty", 64'(oFIFO_EMPTY), 1);
    chk("rst_full",  64'(oFIFO_FULL), 0);
    chk("rst_wren",  64'(oMTIP_WREN), 0);
    chk("rst_frm",   64'(oFRM_CNT), 0);
    chk("rst_drop",  64'(oDROP_CNT), 0);
    iRESET = 1'b0;
    idle(2);

    // 1) single 4-word frame, sink always ready
    iMTIP_RDY = 1'b1;
    gap_q.delete();
    n0 = n_seen;
    send_frame(4, 1'b0);
    drain();
    chk("t1_words", 64'(n_seen - n0), 4);
    chk("t1_gapn", 64'(gap_q.size()), 4);
    s = 0;
    for (int i = 1; i < gap_q.size(); i++)
      s += gap_q[i];
    chk("t1_consec", 64'(s), 0);
    chk("t1_frm", 64'(oFRM_CNT), 0);

    // 2) three buffered 3-word frames, exact IPG
    iMTIP_RDY = 1'b0;
    for (int f = 0; f < 3; f++)
      send_frame(3, 1'b0);
    chk("t2_frm3", 64'(oFRM_CNT), 3);
    sop_gap_q.delete();
    iMTIP_RDY = 1'b1;
    drain();
    chk("t2_nsop", 64'(sop_gap_q.size()), 3);
    if (sop_gap_q.size() == 3) begin
      chk("t2_gap1", 64'(sop_gap_q[1]), IPG);
      chk("t2_gap2", 64'(sop_gap_q[2]), IPG);
    end
    chk("t2_empty", 64'(oFIFO_EMPTY), 1);

    // 3) sink stall of 3 cycles after 2nd output word
    iMTIP_RDY = 1'b0;
    send_frame(6, 1'b1);
    chk("t3_frm1", 64'(oFRM_CNT), 1);
    gap_q.delete();
    n0 = n_seen;
    iMTIP_RDY = 1'b1;
    wait_seen(n0 + 2);
    iMTIP_RDY = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("t3_frm_mid", 64'(oFRM_CNT), 1);
    iMTIP_RDY = 1'b1;
    drain();
    chk("t3_gapn", 64'(gap_q.size()), 6);
    s  = 0;
    mx = 0;
    for (int i = 1; i < gap_q.size(); i++) begin
      s += gap_q[i];
      if (gap_q[i] > mx)
        mx = gap_q[i];
    end
    chk("t3_gap_sum", 64'(s), 3);
    chk("t3_gap_max", 64'(mx), 3);
    chk("t3_frm0", 64'(oFRM_CNT), 0);

    // 4) orphan word, then frame with a stray mid-frame SOP
    d0 = oDROP_CNT;
    sop_gap_q.delete();
    put_word($urandom, 1'b0, 1'b0, 1'b0);
    put_word($urandom, 1'b1, 1'b0, 1'b0);
    put_word($urandom, 1'b0, 1'b0, 1'b0);
    put_word($urandom, 1'b1, 1'b0, 1'b0);
    put_word($urandom, 1'b0, 1'b1, 1'b0);
    drain();
    chk("t4_drop_delta", 64'(oDROP_CNT - d0), 2);
    chk("t4_drop", 64'(oDROP_CNT), 64'(m_drop));
    chk("t4_nsop", 64'(sop_gap_q.size()), 1);

    // 5) oversize frame fills buffer, cut-through
    iMTIP_RDY = 1'b0;
    n0 = n_seen;
    for (int i = 0; i < DEPTH; i++)
      put_word($urandom, i == 0, 1'b0, 1'b0);
    chk("t5_rdy", 64'(oRDY), 0);
    chk("t5_full", 64'(oFIFO_FULL), 1);
    chk("t5_frm", 64'(oFRM_CNT), 0);
    iMTIP_RDY = 1'b1;
    for (int i = 0; i < 4; i++)
      put_word($urandom, 1'b0, i == 3, 1'b0);
    drain();
    chk("t5_words", 64'(n_seen - n0), DEPTH + 4);
    chk("t5_empty", 64'(oFIFO_EMPTY), 1);
    chk("t5_drop", 64'(oDROP_CNT), 64'(m_drop));

    // 6) reset in the middle of output
    iMTIP_RDY = 1'b0;
    send_frame(6, 1'b0);
    n0 = n_seen;
    iMTIP_RDY = 1'b1;
    wait_seen(n0 + 2);
    #1;
    iRESET = 1'b1;
    exp_q.delete();
    m_in   = 1'b0;
    m_drop = 0;
    #1;
    chk("t6_wren",  64'(oMTIP_WREN), 0);
    chk("t6_empty", 64'(oFIFO_EMPTY), 1);
    chk("t6_frm",   64'(oFRM_CNT), 0);
    chk("t6_drop",  64'(oDROP_CNT), 0);
    chk("t6_rdy",   64'(oRDY), 1);
    repeat (2) @(negedge iCLK);
    iRESET = 1'b0;
    n0 = n_seen;
    repeat (4) @(negedge iCLK);
    chk("t6_no_pulse", 64'(n_seen - n0), 0);
    send_frame(3, 1'b0);
    drain();
    chk("t6_words", 64'(n_seen - n0), 3);

    // 7) randomized frames, junk words and sink backpressure
    rnd_rdy = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int len;
      if ($urandom_range(0, 3) == 0)
        put_word($urandom, 1'b0, 1'($urandom), 1'b0);
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        put_word($urandom,
                 (i == 0) || ($urandom_range(0, 9) == 0),
                 i == len - 1,
                 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end
    drain();
    rnd_rdy   = 1'b0;
    iMTIP_RDY = 1'b1;
    idle(4);
    chk("t7_drop",  64'(oDROP_CNT), 64'(m_drop));
    chk("t7_frm",   64'(oFRM_CNT), 0);
    chk("t7_empty", 64'(oFIFO_EMPTY), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
